// File: rtl/mult_seq_ctrl_if.sv
// mult_seq_ctrl_if: switch/button inputs, adder/subtractor hookup and product outputs of the multiplier sequencer.
interface mult_seq_ctrl_if #(parameter int N = 8);
    logic         run;
    logic         clear_a_load_b;
    logic [N-1:0] sw;
    logic [N-1:0] addsub_a;
    logic [N-1:0] addsub_b;
    logic         addsub_fn;
    logic [N:0]   addsub_s;
    logic [N-1:0] aval;
    logic [N-1:0] bval;
    logic         x;
    logic         done;

    modport slave (
        input  run, clear_a_load_b, sw, addsub_s,
        output addsub_a, addsub_b, addsub_fn, aval, bval, x, done
    );

    modport master (
        output run, clear_a_load_b, sw, addsub_s,
        input  addsub_a, addsub_b, addsub_fn, aval, bval, x, done
    );
endinterface

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: add/shift sequencer for an NxN signed multiplier; {A,B} holds the 2N-bit product.
module mult_seq_ctrl #(parameter int N = 8) (
    input logic clk,
    input logic rst,
    mult_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

    state_t               state;
    logic [N-1:0]         a, b, m;
    logic                 x, done;
    logic [$clog2(N)-1:0] cnt;

    // The multiplier's sign bit carries negative weight, so the last step subtracts.
    assign bus.addsub_fn = (state == ADD) && (cnt == N-1);
    assign bus.addsub_a  = a;
    assign bus.addsub_b  = m;
    assign bus.aval      = a;
    assign bus.bval      = b;
    assign bus.x         = x;
    assign bus.done      = done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a     <= '0;
            b     <= '0;
            m     <= '0;
            x     <= 1'b0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.clear_a_load_b) begin
                        a <= '0;
                        x <= 1'b0;
                        b <= bus.sw;
                    end else if (bus.run) begin
                        m     <= bus.sw;
                        a     <= '0;
                        x     <= 1'b0;
                        cnt   <= '0;
                        state <= ADD;
                    end
                end
                ADD: begin
                    if (b[0])
                        {x, a} <= bus.addsub_s;
                    state <= SHIFT;
                end
                SHIFT: begin
                    a <= {x, a[N-1:1]};
                    b <= {a[0], b[N-1:1]};
                    if (cnt == N-1) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        state <= ADD;
                    end
                end
                default: begin
                    if (!bus.run) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl: directed vectors and hand sequences for the signed shift-add multiplier sequencer.
module tb_mult_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mult_seq_ctrl_if #(.N(8)) bus ();
    mult_seq_ctrl #(.N(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Reference 9-bit sign-extended adder/subtractor.
    assign bus.addsub_s = bus.addsub_fn ? {bus.addsub_a[7], bus.addsub_a} - {bus.addsub_b[7], bus.addsub_b}
                                        : {bus.addsub_a[7], bus.addsub_a} + {bus.addsub_b[7], bus.addsub_b};

    typedef struct {
        logic [7:0] ld;
        logic [7:0] mc;
        logic [7:0] ea;
        logic [7:0] eb;
        logic       ex;
        logic       a_zero;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        bus.clear_a_load_b = 1'b1;
        bus.sw = v;
        step();
        bus.clear_a_load_b = 1'b0;
    endtask

    // Accepts a multiply, scrambles sw, waits for done and checks latency, subtract timing and product.
    // run is left high for the caller to release.
    task automatic mult(input logic [7:0] mc, input logic [7:0] ea, input logic [7:0] eb,
                        input logic ex, input logic a_zero);
        int n = 0;
        int fn_hits = 0;
        int fn_at = -1;
        bus.run = 1'b1;
        bus.sw = mc;
        step();
        bus.sw = ~mc;
        while (!bus.done && n < 40) begin
            if (bus.addsub_fn) begin
                fn_hits++;
                fn_at = n;
            end
            if (a_zero) check("a_stays_zero", {8'h0, bus.aval}, 16'h0);
            step();
            n++;
        end
        check("latency", n[15:0], 16'd16);
        check("fn_count", fn_hits[15:0], 16'd1);
        check("fn_cycle", fn_at[15:0], 16'd14);
        check("product", {bus.aval, bus.bval}, {ea, eb});
        check("x", {15'h0, bus.x}, {15'h0, ex});
    endtask

    initial begin
        vecs[0] = '{8'hFD, 8'h07, 8'hFF, 8'hEB, 1'b1, 1'b0};
        vecs[1] = '{8'h80, 8'h80, 8'h40, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{8'h00, 8'h5A, 8'h00, 8'h00, 1'b0, 1'b1};
        vecs[3] = '{8'h7F, 8'h7F, 8'h3F, 8'h01, 1'b0, 1'b0};
        vecs[4] = '{8'h01, 8'h80, 8'hFF, 8'h80, 1'b1, 1'b0};
        vecs[5] = '{8'hFF, 8'hFF, 8'h00, 8'h01, 1'b0, 1'b0};

        bus.run = 1'b0;
        bus.clear_a_load_b = 1'b0;
        bus.sw = 8'h00;
        step();
        step();
        rst = 1'b0;
        check("reset_ab", {bus.aval, bus.bval}, 16'h0);
        check("reset_x_done_fn", {13'h0, bus.x, bus.done, bus.addsub_fn}, 16'h0);

        // Reset in the middle of a multiply
        load(8'h55);
        bus.run = 1'b1;
        bus.sw = 8'h33;
        step();
        bus.run = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_ab", {bus.aval, bus.bval}, 16'h0);
        check("midrst_x_done", {14'h0, bus.x, bus.done}, 16'h0);
        repeat (3) step();
        check("midrst_idle", {bus.aval, bus.bval}, 16'h0);

        for (int i = 0; i < 6; i++) begin
            load(vecs[i].ld);
            mult(vecs[i].mc, vecs[i].ea, vecs[i].eb, vecs[i].ex, vecs[i].a_zero);
            bus.run = 1'b0;
            step();
            check("idle_done", {15'h0, bus.done}, 16'h0);
            check("idle_hold", {bus.aval, bus.bval}, {vecs[i].ea, vecs[i].eb});
        end

        // Load has priority over Run in IDLE
        bus.run = 1'b1;
        bus.clear_a_load_b = 1'b1;
        bus.sw = 8'h12;
        step();
        bus.run = 1'b0;
        bus.clear_a_load_b = 1'b0;
        check("load_prio_b", {8'h0, bus.bval}, 16'h0012);
        repeat (3) step();
        check("load_prio_idle", {7'h0, bus.done, bus.bval}, 16'h0012);

        // Run held through DONE, then a second press reuses B
        load(8'h03);
        mult(8'h02, 8'h00, 8'h06, 1'b0, 1'b0);
        repeat (5) step();
        check("held_done", {15'h0, bus.done}, 16'h1);
        check("held_product", {bus.aval, bus.bval}, 16'h0006);
        bus.clear_a_load_b = 1'b1;
        step();
        bus.clear_a_load_b = 1'b0;
        check("load_ignored_done", {bus.aval, bus.bval}, 16'h0006);
        bus.run = 1'b0;
        step();
        check("between_done", {15'h0, bus.done}, 16'h0);
        check("between_product", {bus.aval, bus.bval}, 16'h0006);
        mult(8'h02, 8'h00, 8'h0C, 1'b0, 1'b0);
        bus.run = 1'b0;
        step();
        check("second_idle", {7'h0, bus.done, bus.bval}, 16'h000C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
